// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// drops stale responses after redirects. Optional FETCH_STALL_CNT_EN adds stallCnt.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        validF
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stallCnt
`endif
);

  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr_buf;
  logic [31:0] tgt;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirectPC & ~32'h0000_0003;
  assign pc_plus4     = pc + 32'd4;

  // Handshake and IF/ID-facing outputs follow state and the live response
  always_comb begin
    imemReq  = !rst && (state == FETCH || state == DISCARD);
    imemAddr = pc;
    PCF      = pc;
    PCPlus4F = pc_plus4;
    validF   = !rst && !redirect &&
               ((state == FETCH && imemReady) || state == HOLD);
    instrF   = 32'h0;
    if (validF) begin
      instrF = (state == HOLD) ? instr_buf : imemRdata;
    end
  end

  // PC / state machine; redirect outranks stall and normal sequencing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr_buf <= 32'h0;
      tgt       <= 32'h0;
    end else if (redirect) begin
      if ((state == FETCH || state == DISCARD) && !imemReady) begin
        tgt   <= redirect_tgt;
        state <= DISCARD;
      end else begin
        pc    <= redirect_tgt;
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imemReady) begin
            if (stallF) begin
              instr_buf <= imemRdata;
              state     <= HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        HOLD: begin
          if (!stallF) begin
            pc    <= pc_plus4;
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (imemReady) begin
            pc    <= tgt;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // Saturating count of cycles spent waiting on memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'h0;
    end else if (imemReq && !imemReady && stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stallCnt = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stimulus with a scoreboard of
// expected (PC, instruction) pairs consumed on every validF cycle.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        validF;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stallCnt;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .stallF(stallF),
    .redirect(redirect),
    .redirectPC(redirectPC),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemReady(imemReady),
    .imemRdata(imemRdata),
    .instrF(instrF),
    .PCF(PCF),
    .PCPlus4F(PCPlus4F),
    .validF(validF)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stallCnt(stallCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [31:0] rd, input logic stl,
                       input logic rdr, input logic [31:0] rpc);
    imemReady  = rdy;
    imemRdata  = rd;
    stallF     = stl;
    redirect   = rdr;
    redirectPC = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch of one word at the expected PC
  task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] data);
    drive(1'b1, data, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc: pc, instr: data});
    @(negedge clk);
    check("fetch_addr", imemAddr, pc);
    check("fetch_req", 32'(imemReq), 32'd1);
    tick();
  endtask

  // Scoreboard consumer: every valid cycle must match the oldest expectation
  always @(negedge clk) begin
    if (validF === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", PCF, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_pcf", PCF, e.pc);
        check("sb_instr", instrF, e.instr);
        check("sb_pcplus4", PCPlus4F, e.pc + 32'd4);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", 32'(imemReq), 32'd0);
    check("rst_valid", 32'(validF), 32'd0);
    check("rst_instr", instrF, 32'h0);
    check("rst_pcf", PCF, 32'h0);
    check("rst_pcplus4", PCPlus4F, 32'h4);
`ifdef FETCH_STALL_CNT_EN
    check("rst_stallcnt", stallCnt, 32'h0);
`endif
    tick();
    rst = 1'b0;

    // Zero-wait stream from reset
    for (int i = 0; i < 4; i++) fetch_ok(32'(i * 4), 32'(i * 4) ^ 32'hA5A5_0000);

    // Three-cycle memory wait at 0x10
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check("wait_req", 32'(imemReq), 32'd1);
      check("wait_addr", imemAddr, 32'h10);
      check("wait_valid", 32'(validF), 32'd0);
      check("wait_instr", instrF, 32'h0);
      tick();
    end
`ifdef FETCH_STALL_CNT_EN
    @(negedge clk);
    check("stallcnt_3", stallCnt, 32'd3);
    @(posedge clk);
    #1;
    sb.push_back('{pc: 32'h10, instr: 32'h1234_5678});
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("wait_done_addr", imemAddr, 32'h10);
    tick();
`else
    fetch_ok(32'h10, 32'h1234_5678);
`endif

    // Stall while the response at 0x20 arrives
    for (int a = 'h14; a < 'h20; a += 4) fetch_ok(32'(a), 32'(a) + 32'h100);
    drive(1'b1, 32'hCAFE_0020, 1'b1, 1'b0, 32'h0);
    sb.push_back('{pc: 32'h20, instr: 32'hCAFE_0020});
    @(negedge clk);
    check("stall_cap_addr", imemAddr, 32'h20);
    tick();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    sb.push_back('{pc: 32'h20, instr: 32'hCAFE_0020});
    @(negedge clk);
    check("hold_req", 32'(imemReq), 32'd0);
    check("hold_pcf", PCF, 32'h20);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc: 32'h20, instr: 32'hCAFE_0020});
    @(negedge clk);
    check("hold_release_req", 32'(imemReq), 32'd0);
    tick();
    for (int a = 'h24; a < 'h40; a += 4) fetch_ok(32'(a), ~32'(a));

    // Redirect to 0x103 while request at 0x40 is pending
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    @(negedge clk);
    check("redir_valid", 32'(validF), 32'd0);
    check("redir_req", 32'(imemReq), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("discard_req", 32'(imemReq), 32'd1);
    check("discard_addr", imemAddr, 32'h40);
    tick();
    drive(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("discard_drop", 32'(validF), 32'd0);
    tick();

    // Back-to-back redirects during DISCARD: only the last target survives
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    @(negedge clk);
    check("redir_tgt_addr", imemAddr, 32'h100);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0300);
    @(negedge clk);
    check("redir2_valid", 32'(validF), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("discard2_addr", imemAddr, 32'h100);
    tick();
    drive(1'b1, 32'hBAD1_BAD1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("discard2_drop", 32'(validF), 32'd0);
    tick();
    drive(1'b1, 32'h0000_0300, 1'b1, 1'b0, 32'h0);
    sb.push_back('{pc: 32'h300, instr: 32'h0000_0300});
    @(negedge clk);
    check("b2b_addr", imemAddr, 32'h300);
    tick();

    // Redirect together with stallF while in HOLD
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0400);
    @(negedge clk);
    check("hold_redir_valid", 32'(validF), 32'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    @(negedge clk);
    check("hold_redir_addr", imemAddr, 32'h400);
    check("hold_redir_req", 32'(imemReq), 32'd1);
    tick();
    drive(1'b1, 32'hBAD2_BAD2, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("discard3_drop", 32'(validF), 32'd0);
    tick();

    // PC wrap at the top of the address space
    drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 32'h0);
    sb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h7777_7777});
    @(negedge clk);
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_pcplus4", PCPlus4F, 32'h0);
    tick();
    fetch_ok(32'h0, 32'h1111_0000);

    // Reset asserted in the middle of a wait at 0x4
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_rst_addr", imemAddr, 32'h4);
    rst = 1'b1;
    #1;
    check("mid_rst_pcf", PCF, 32'h0);
    check("mid_rst_valid", 32'(validF), 32'd0);
    check("mid_rst_req", 32'(imemReq), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req", 32'(imemReq), 32'd1);
    check("post_rst_addr", imemAddr, 32'h0);
    tick();

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core. It owns the program counter, issues word fetches to instruction memory over a variable-latency req/ready handshake, and presents instrF/PCF/PCPlus4F plus a validF qualifier to the IF/ID pipeline register. It handles stalls from the hazard unit and PC redirects from the branch/jump logic. It also drops any memory response that a redirect has made stale.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stallF  in  1  hold request from hazard unit; same signal that deasserts the IF/ID enable.
- redirect  in  1  taken branch/jump; has priority over everything except rst.
- redirectPC  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- imemReq  out  1  fetch request to instruction memory.
- imemAddr  out  32  fetch address; equals the internal PC register.
- imemReady  in  1  memory response strobe; imemRdata is valid in the same cycle.
- imemRdata  in  32  fetched instruction word.
- instrF  out  32  instruction presented to IF/ID.
- PCF  out  32  PC of instrF.
- PCPlus4F  out  32  PCF + 4, modulo 2^32.
- validF  out  1  instrF is real; 0 means IF/ID must load a bubble (drive its clr).
- stallCnt  out  32  memory-wait counter; present only with FETCH_STALL_CNT_EN.

## Operation
- State machine with three states:
  - FETCH: request outstanding for PC.
  - HOLD: response buffered while stallF is high.
  - DISCARD: waiting on a stale response after a redirect.
- imemReq = !rst && (state==FETCH || state==DISCARD). imemAddr = PC, held stable while imemReq=1 and imemReady=0.
- FETCH with imemReady=1:
  - redirect=0, stallF=0: validF=1, instrF=imemRdata (combinational). PC<=PC+4. Stay in FETCH.
  - redirect=0, stallF=1: validF=1, instrF=imemRdata. Capture imemRdata into instrBuf. Go to HOLD; PC unchanged.
- FETCH with imemReady=0: validF=0, instrF=32'h0.
- HOLD:
  - imemReq=0, validF=1, instrF=instrBuf, PC held.
  - When stallF=0: PC<=PC+4, go to FETCH.
- DISCARD:
  - imemReq=1 at the old address. validF=0 and imemRdata is ignored.
  - On imemReady: PC<=tgt, go to FETCH.
- redirect=1, any state:
  - validF=0 in that cycle.
  - FETCH with imemReady=0: latch tgt<=redirectPC&~3, go to DISCARD.
  - Otherwise (FETCH with imemReady=1, HOLD, or DISCARD with imemReady=1): PC<=redirectPC&~3, go to FETCH.
  - DISCARD with imemReady=0: tgt is overwritten by the new redirectPC.
- redirect together with stallF: redirect wins; the stall is ignored for that cycle.
- PCF = PC; PCPlus4F = PC+4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0).

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH, instrBuf=0, tgt=0, stallCnt=0.
  - Outputs: imemReq=0, validF=0, instrF=0, PCF=RESET_PC, PCPlus4F=RESET_PC+4.
- The first request appears in the first cycle after rst falls.
- Zero-wait memory (imemReady=1 whenever requested): one valid instruction per cycle, with PC advancing by 4 on every edge.
- Fetch latency: instrF is valid in the same cycle as imemReady; IF/ID captures it on the following edge.
- Redirect penalty: the first target fetch is issued in the cycle after redirect. If a stale request was in flight, it is issued in the cycle after that request's imemReady.
- rst mid-request: the state machine returns to FETCH at RESET_PC immediately. Any later imemReady from the old request is memory's responsibility; memory must also be reset.

## Configuration
- FETCH_STALL_CNT_EN defined:
  - Adds the stallCnt output.
  - Increments by 1 on each cycle where imemReq=1 and imemReady=0, saturating at 32'hFFFF_FFFF.
  - Reset value 0.
- Undefined: stallCnt port and counter logic are absent. All other behaviour is identical.

## Test plan
- Reset release, RESET_PC=0, imemReady tied 1, imemRdata=PC^32'hA5A5_0000 -> PCF 0,4,8,C on consecutive cycles; validF=1 each cycle; PCPlus4F=PCF+4.
- Memory wait of 3 cycles at PC=0x10, rdata=0x1234_5678 -> imemReq=1 and imemAddr=0x10 held 3 cycles with validF=0. On the 4th cycle validF=1 and instrF=0x1234_5678. stallCnt=3 with the macro.
- stallF=1 for 2 cycles while the response at PC=0x20 arrives -> HOLD, imemReq=0, instrF held, PCF=0x20. After stallF falls, the next PCF is 0x24.
- redirect to 0x103 while PC=0x40 and the request is pending; memory answers 2 cycles later -> DISCARD, validF=0, stale data dropped. The next imemAddr is 0x100.
- Back-to-back redirects 0x200 then 0x300 during DISCARD -> only 0x300 is fetched; redirect with stallF=1 in HOLD also goes directly to FETCH at the target.
- PC=0xFFFF_FFFC fetched with stallF=0 -> next PCF=0x0; PCPlus4F=0x0 while PCF=0xFFFF_FFFC. Asserting rst mid-wait returns PCF to RESET_PC with validF=0.
